// File: rtl/mux_4x1_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux_4x1_rr_arbiter
//
// Shares one N-bit 4:1 mux output channel between four requesters. One
// requester is picked, its word is registered onto a valid/ready output
// port, and the winner is acked in the cycle the consumer accepts the word.
// After every accepted word the arbiter re-arbitrates immediately, so with
// out_ready held high one word per cycle is delivered.
//
// Arbitration:
//   - default build : round robin, searching from (last granted + 1) mod 4.
//   - MUX_ARB_FIXED_PRIO_EN defined : fixed priority req0 > req1 > req2 > req3.
//   In both builds, the requester whose word is accepted this cycle is masked
//   out of the re-arbitration, because its req is still high in that cycle.
//
// Parameters:
//   N          data width of each input word and of out_data
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req[3:0]   request per requester, held until the matching ack
//   in0..in3   requester data words, stable while the request is high
//   out_ready  consumer accepts out_data this cycle
//   out_valid  out_data holds a word awaiting acceptance
//   out_data   registered word of the granted requester
//   sel[1:0]   index of the current / last granted requester (mux select)
//   grant[3:0] one-hot current grant, zero when idle
//   ack[3:0]   one-cycle pulse in the cycle requester i's word is accepted
// ---------------------------------------------------------------------------
module mux_4x1_rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req,
    input  logic [N-1:0] in0,
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    input  logic [N-1:0] in3,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    output logic [1:0]   sel,
    output logic [3:0]   grant,
    output logic [3:0]   ack
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     sel_q, sel_d;
    logic [3:0]     grant_q, grant_d;
    logic [N-1:0]   out_data_q, out_data_d;

`ifndef MUX_ARB_FIXED_PRIO_EN
    logic [1:0]     last_q, last_d;
`endif

    // Data inputs gathered into an array so the mux is a simple index.
    logic [N-1:0]   in_arr [4];
    assign in_arr[0] = in0;
    assign in_arr[1] = in1;
    assign in_arr[2] = in2;
    assign in_arr[3] = in3;

    // A transfer happens whenever a word is held and the consumer takes it.
    logic xfer;
    assign xfer = (state_q == BUSY) && out_ready;

    // ------------------------------------------------------------------
    // Candidate mask and search start for this cycle's arbitration.
    // In BUSY the current winner's req is still high, so it is masked.
    // ------------------------------------------------------------------
    logic [3:0] cand_mask;
    logic [1:0] search_start;

    always_comb begin
        cand_mask    = 4'b0000;
        search_start = 2'd0;
        if (state_q == IDLE) begin
            cand_mask = req;
`ifndef MUX_ARB_FIXED_PRIO_EN
            search_start = last_q + 2'd1;
`endif
        end else if (xfer) begin
            cand_mask = req & ~grant_q;
`ifndef MUX_ARB_FIXED_PRIO_EN
            // last becomes sel on this edge, so sel+1 is the new last+1.
            search_start = sel_q + 2'd1;
`endif
        end
    end

    // ------------------------------------------------------------------
    // First set bit of cand_mask at or after search_start, wrapping 3->0.
    // With search_start fixed at 0 this degenerates to fixed priority.
    // ------------------------------------------------------------------
    logic       win_found;
    logic [1:0] win_idx;

    always_comb begin
        logic [1:0] idx;
        win_found = 1'b0;
        win_idx   = 2'd0;
        idx       = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = search_start + 2'(k);
            if (!win_found && cand_mask[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    logic [3:0] win_onehot;
    assign win_onehot = 4'(4'b0001 << win_idx);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        grant_d    = grant_q;
        out_data_d = out_data_q;
`ifndef MUX_ARB_FIXED_PRIO_EN
        last_d     = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d    = BUSY;
                    sel_d      = win_idx;
                    grant_d    = win_onehot;
                    out_data_d = in_arr[win_idx];
                end
            end
            BUSY: begin
                // Without out_ready everything is frozen, including
                // arbitration, so late or withdrawn requests are ignored.
                if (out_ready) begin
`ifndef MUX_ARB_FIXED_PRIO_EN
                    last_d = sel_q;
`endif
                    if (win_found) begin
                        sel_d      = win_idx;
                        grant_d    = win_onehot;
                        out_data_d = in_arr[win_idx];
                    end else begin
                        // out_data and sel intentionally keep their values.
                        state_d = IDLE;
                        grant_d = 4'b0000;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sel_q      <= 2'd0;
            grant_q    <= 4'b0000;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            grant_q    <= grant_d;
            out_data_q <= out_data_d;
        end
    end

`ifndef MUX_ARB_FIXED_PRIO_EN
    // Starts at 3 so requester 0 has first priority after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 2'd3;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs. ack depends only on state, out_ready and sel, never on req.
    // ------------------------------------------------------------------
    assign out_valid = (state_q == BUSY);
    assign out_data  = out_data_q;
    assign sel       = sel_q;
    assign grant     = grant_q;
    assign ack       = xfer ? 4'(4'b0001 << sel_q) : 4'b0000;

endmodule

// File: tb/tb_mux_4x1_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux_4x1_rr_arbiter
//
// Directed testbench for mux_4x1_rr_arbiter (N=4). Inputs are driven 1 ns
// after the rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mux_4x1_rr_arbiter;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req;
    logic [N-1:0] in0, in1, in2, in3;
    logic         out_ready;
    logic         out_valid;
    logic [N-1:0] out_data;
    logic [1:0]   sel;
    logic [3:0]   grant;
    logic [3:0]   ack;

    int checks;
    int failures;

    mux_4x1_rr_arbiter #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .sel       (sel),
        .grant     (grant),
        .ack       (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs packed as {out_valid, out_data, sel, grant, ack}.
    logic [14:0] obs;
    assign obs = {out_valid, out_data, sel, grant, ack};

    // Leaves the bench 1 ns after a rising edge with reset released.
    task automatic do_reset();
        req       = 4'b0000;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [14:0] exp_v;
        in0 = 4'b0101; in1 = 4'b0011; in2 = 4'b0100; in3 = 4'b1000;
        do_reset();
        exp_v = {1'b0, 4'b0000, 2'b00, 4'b0000, 4'b0000};
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL reset_idle cycle %0d: got %b required %b", c, obs, exp_v);
            end else
                $display("reset_idle cycle %0d ok: %b", c, obs);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_latency: out_valid got %b required 0", out_valid);
        end else
            $display("single_latency ok");
        @(negedge clk);
        checks++;
        if (obs !== {1'b1, 4'b0100, 2'b10, 4'b0100, 4'b0100}) begin
            failures++;
            $display("FAIL single_xfer: got %b required %b", obs,
                     {1'b1, 4'b0100, 2'b10, 4'b0100, 4'b0100});
        end else
            $display("single_xfer ok: %b", obs);
        @(posedge clk); #1 req = 4'b0000;
        @(negedge clk);
        checks++;
        if (obs !== {1'b0, 4'b0100, 2'b10, 4'b0000, 4'b0000}) begin
            failures++;
            $display("FAIL single_idle: got %b required %b", obs,
                     {1'b0, 4'b0100, 2'b10, 4'b0000, 4'b0000});
        end else
            $display("single_idle ok: %b", obs);
    endtask

    task automatic test_round_robin();
        int         exp_sel [5] = '{0, 1, 2, 3, 0};
        logic [3:0] exp_dat [5] = '{4'b0101, 4'b0011, 4'b0100, 4'b1000, 4'b0101};
        logic [3:0] dropped;
        do_reset();
        req = 4'b1111; out_ready = 1'b1;
        dropped = 4'b0000;
        @(posedge clk); #1;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || sel !== 2'(exp_sel[t]) || out_data !== exp_dat[t]
                || ack !== 4'(4'b0001 << exp_sel[t])) begin
                failures++;
                $display("FAIL rr_word %0d: got valid=%b sel=%0d data=%b ack=%b required sel=%0d data=%b",
                         t, out_valid, sel, out_data, ack, exp_sel[t], exp_dat[t]);
            end else
                $display("rr_word %0d ok: sel=%0d data=%b", t, sel, out_data);
            @(posedge clk); #1;
            // The acked requester drops for one cycle, the previous one re-raises.
            req     = (req | dropped) & ~(4'(4'b0001 << exp_sel[t]));
            dropped = 4'(4'b0001 << exp_sel[t]);
        end
        req = 4'b0000;
    endtask

    task automatic test_backpressure();
        do_reset();
        req = 4'b0010; out_ready = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 4'b0011 || ack !== 4'b0000) begin
                failures++;
                $display("FAIL bp_hold %0d: got valid=%b data=%b ack=%b required 1 0011 0000",
                         c, out_valid, out_data, ack);
            end else
                $display("bp_hold %0d ok", c);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (ack !== 4'b0010) begin
            failures++;
            $display("FAIL bp_ack: got %b required 0010", ack);
        end else
            $display("bp_ack ok");
        @(posedge clk); #1 req = 4'b0000;
        @(negedge clk);
        checks++;
        if (ack !== 4'b0000 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_ack_once: got ack=%b valid=%b required 0000 0", ack, out_valid);
        end else
            $display("bp_ack_once ok");
    endtask

    // req=1001 held: same order 0,3,0 in both builds since the accepted
    // requester is masked on re-arbitration.
    task automatic test_no_double_win();
        int         exp_sel [3] = '{0, 3, 0};
        logic [3:0] exp_dat [3] = '{4'b0101, 4'b1000, 4'b0101};
        do_reset();
        req = 4'b1001; out_ready = 1'b1;
        @(posedge clk); #1;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            checks++;
            if (sel !== 2'(exp_sel[t]) || out_data !== exp_dat[t] || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL alt_word %0d: got sel=%0d data=%b valid=%b required sel=%0d data=%b",
                         t, sel, out_data, out_valid, exp_sel[t], exp_dat[t]);
            end else
                $display("alt_word %0d ok: sel=%0d", t, sel);
            @(posedge clk); #1;
        end
        req = 4'b0000;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b1000; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'b1000) begin
            failures++;
            $display("FAIL mid_busy: got valid=%b data=%b required 1 1000", out_valid, out_data);
        end else
            $display("mid_busy ok");
        #2;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 4'b0000 || ack !== 4'b0000 || grant !== 4'b0000) begin
            failures++;
            $display("FAIL mid_reset: got valid=%b data=%b ack=%b grant=%b required 0 0000 0000 0000",
                     out_valid, out_data, ack, grant);
        end else
            $display("mid_reset ok");
        @(negedge clk);
        checks++;
        if (ack !== 4'b0000 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_hold: got ack=%b valid=%b required 0000 0", ack, out_valid);
        end else
            $display("mid_reset_hold ok");
        req   = 4'b0000;
        rst_n = 1'b1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        req       = 4'b0000;
        out_ready = 1'b0;
        in0 = 4'b0101; in1 = 4'b0011; in2 = 4'b0100; in3 = 4'b1000;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_no_double_win();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
